sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//   Bus controller for the NTSC Shield asynchronous SRAM (1M x 8).
//   - Turns single-cycle mem/rw requests from the test and video engines into timed
//     CE#/OE#/WE# strobe sequences on the SRAM pins.
//   - Returns read data and a ready handshake.
//   - Sits directly downstream of the SRAM test sequencer and owns the bidirectional data bus.
// PARAMETERS
//   ADDR_W   20  address width, in bits
//   DATA_W   8   data width, in bits
//   RD_WAIT  2   cycles OE# is held low per read (range 1..15); 20 ns/cycle at 50 MHz
//   WR_WAIT  2   cycles WE# is held low per write (range 1..15)
// PORTS
//   clk        in     1       50 MHz system clock
//   rst        in     1       synchronous reset, active-low
//   mem        in     1       request strobe; sampled only while ready=1
//   rw         in     1       1 = read, 0 = write; sampled together with mem
//   ready      out    1       controller idle; can accept a request this cycle
//   addr       in     ADDR_W  request address
//   data2ram   in     DATA_W  write data
//   data2fpga  out    DATA_W  registered read data; valid from the cycle ready rises after a read
//   sram_addr  out    ADDR_W  SRAM address pins (registered)
//   sram_dq    inout  DATA_W  SRAM data pins
//   sram_ce_n  out    1       chip enable, active-low
//   sram_oe_n  out    1       output enable, active-low
//   sram_we_n  out    1       write enable, active-low
// BEHAVIOUR
//   - Reset (rst=0 at a clk edge):
//     - state=IDLE, ready=1, data2fpga=0, sram_addr=0.
//     - sram_ce_n=1, sram_oe_n=1, sram_we_n=1; sram_dq released to Z.
//     - Reset mid-operation aborts the access at that edge; the strobes deassert immediately.
//   - Acceptance: mem=1 && ready=1 at an edge latches rw, addr and data2ram.
//     - ready=0 from the next cycle.
//     - mem while ready=0 is ignored; there is no queue.
//   - FSM states: IDLE, RD, WR, WR_HOLD, (TURN).
//   - IDLE -> RD (rw=1): sram_addr=addr, ce_n=0, oe_n=0, dq=Z for RD_WAIT cycles.
//     - On the last RD cycle, sram_dq is registered into data2fpga.
//     - Then -> IDLE with oe_n=ce_n=1.
//   - IDLE -> WR (rw=0): sram_addr=addr, ce_n=0, dq driven with data2ram, we_n=0 for WR_WAIT cycles.
//     - -> WR_HOLD for 1 cycle: we_n=1, ce_n=0, dq still driven (data hold time).
//     - Then -> IDLE, dq=Z.
//   - Latency from the accept edge to ready=1:
//     - read:  RD_WAIT+1 cycles
//     - write: WR_WAIT+2 cycles
//   - Back-to-back: mem held high is accepted again on the first ready=1 cycle. No bubble
//     except the TURN cycle (see CONFIGURATION).
//   - Strobe ordering: we_n and oe_n are never low in the same cycle.
//     - sram_dq is driven only in WR and WR_HOLD.
//   - Wait counter: 4-bit down-counter, loaded with WAIT-1 on entry; the state exits at 0.
//   - data2fpga holds its last read value through writes and idle.
//   - Address: no wrap logic; addr passes through unmodified at full ADDR_W.
// CONFIGURATION
//   SRAM_CTRL_TURNAROUND_EN
//   - Defined:
//     - A read accepted when the previous op was a write, or a write accepted when the
//       previous op was a read, first spends 1 cycle in TURN.
//     - TURN: all strobes high, dq=Z, ready=0.
//     - That access's latency grows by 1.
//   - Undefined:
//     - The TURN state is absent; the dq drive/release timing alone prevents contention.
// STRUCTURE
//   - Shared header sram_defs.vh holds:
//     - SRAM_ADDR_W=20 and SRAM_DATA_W=8
//     - the state encodings (IDLE/RD/WR/WR_HOLD/TURN, 3 bits)
//     - the RW_READ=1 / RW_WRITE=0 constants
//   - sram_test and the video engines include the same header.
//   - One sub-module, sram_dq_iob: registered output-enable plus tristate buffer for sram_dq,
//     so the IOB packs the drive flops. All FSM and counter logic stays in sram_ctrl.
// TESTING
//   - The bench uses a behavioural async SRAM model with tOE and tWE checkers.
//   1. Reset with rst=0 for 3 cycles -> ready=1, ce_n=oe_n=we_n=1, dq=Z, data2fpga=0.
//   2. Write addr=0x12345, data=0xA5, then read 0x12345.
//      - The write has ready=0 for 4 cycles and we_n low for exactly 2.
//      - The read returns data2fpga=0xA5 when ready rises, 3 cycles after accept.
//   3. mem=1 with rw=1 held for 4 consecutive requests to 0x00000, 0xFFFFF, 0x00001, 0x80000
//      -> each is accepted on the first ready=1 cycle; ready is never high for 2 cycles
//      while mem=1.
//   4. Pulse mem while ready=0 mid-write -> the pulse is ignored; exactly one SRAM access occurs.
//   5. Assert rst=0 on the 2nd WR cycle -> at the next edge we_n=1, ce_n=1, dq=Z, ready=1.
//      - The target location is not checked.
//   6. With SRAM_CTRL_TURNAROUND_EN, write then read -> 1 TURN cycle with all strobes high.
//      - Without the macro: no TURN cycle, and dq is never driven while oe_n=0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the NTSC Shield async SRAM controller: bus widths,
// read/write encoding, FSM state encoding and wait-counter helper.
package sram_ctrl_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 8;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_WR      = 3'd2,
      S_WR_HOLD = 3'd3,
      S_TURN    = 3'd4
   } state_e;

   typedef struct packed {
      state_e     state;
      logic [3:0] cnt;
   } op_start_t;

   // The wait counter counts down to zero, so it is loaded one short.
   function automatic logic [3:0] wait_load(input int cycles);
      return 4'(cycles - 1);
   endfunction

endpackage

// File: rtl/sram_dq_iob.sv
// Drive side of the SRAM data bus: registered output enable and write data
// feeding the tristate buffer, so both flops can be packed into the pad.
module sram_dq_iob #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              oe_d,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   inout  wire  [DATA_W-1:0] dq,
   output logic [DATA_W-1:0] dq_in
);

   logic              oe_q;
   logic [DATA_W-1:0] dout_q;
   logic [DATA_W-1:0] dout_d;

   always_comb begin
      dout_d = load ? din : dout_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         oe_q <= 1'b0;
      end else begin
         oe_q <= oe_d;
      end
   end

   always_ff @(posedge clk) begin
      dout_q <= dout_d;
   end

   assign dq    = oe_q ? dout_q : {DATA_W{1'bz}};
   assign dq_in = dq;

endmodule

// File: rtl/sram_ctrl.sv
// Async SRAM bus controller: single-cycle mem/rw requests become timed CE#/OE#/WE#
// sequences. Define SRAM_CTRL_TURNAROUND_EN to insert a TURN cycle on read/write switches.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int DATA_W  = SRAM_DATA_W,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem,
   input  logic              rw,
   output logic              ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data2ram,
   output logic [DATA_W-1:0] data2fpga,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_dq,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] data2fpga_q, data2fpga_d;
   logic [DATA_W-1:0] dq_in;
   logic              dq_oe_d;
   logic              accept;
   op_start_t         op_new;
`ifdef SRAM_CTRL_TURNAROUND_EN
   logic              rw_q, rw_d;
   logic              prev_vld_q, prev_vld_d;
   logic              prev_wr_q, prev_wr_d;
   op_start_t         op_turn;
`endif

   function automatic op_start_t start_op(input logic op_rw);
      op_start_t s;
      s.state = S_IDLE;
      s.cnt   = 4'd0;
      case (op_rw)
         RW_READ:  begin s.state = S_RD; s.cnt = wait_load(RD_WAIT); end
         RW_WRITE: begin s.state = S_WR; s.cnt = wait_load(WR_WAIT); end
         default:  ;
      endcase
      return s;
   endfunction

   assign accept = mem && ready_q;
   assign op_new = start_op(rw);
`ifdef SRAM_CTRL_TURNAROUND_EN
   assign op_turn = start_op(rw_q);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         ready_q     <= 1'b1;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         sram_addr_q <= '0;
         data2fpga_q <= '0;
`ifdef SRAM_CTRL_TURNAROUND_EN
         rw_q        <= RW_READ;
         prev_vld_q  <= 1'b0;
         prev_wr_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         sram_addr_q <= sram_addr_d;
         data2fpga_q <= data2fpga_d;
`ifdef SRAM_CTRL_TURNAROUND_EN
         rw_q        <= rw_d;
         prev_vld_q  <= prev_vld_d;
         prev_wr_q   <= prev_wr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef SRAM_CTRL_TURNAROUND_EN
      rw_d       = rw_q;
      prev_vld_d = prev_vld_q;
      prev_wr_d  = prev_wr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
`ifdef SRAM_CTRL_TURNAROUND_EN
               rw_d       = rw;
               prev_vld_d = 1'b1;
               prev_wr_d  = (rw == RW_WRITE);
               if (prev_vld_q && (prev_wr_q != (rw == RW_WRITE))) begin
                  state_d = S_TURN;
               end else begin
                  state_d = op_new.state;
                  cnt_d   = op_new.cnt;
               end
`else
               state_d = op_new.state;
               cnt_d   = op_new.cnt;
`endif
            end
         end
         S_TURN: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
            state_d = op_turn.state;
            cnt_d   = op_turn.cnt;
`else
            state_d = S_IDLE;
`endif
         end
         S_RD: begin
            if (cnt_q == 4'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_WR: begin
            if (cnt_q == 4'd0) state_d = S_WR_HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_WR_HOLD: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state; ready also stays low for the
   // first IDLE cycle after an access so CE# gets a high gap between accesses.
   always_comb begin
      ready_d     = (state_q == S_IDLE) && (state_d == S_IDLE);
      ce_n_d      = !((state_d == S_RD) || (state_d == S_WR) || (state_d == S_WR_HOLD));
      oe_n_d      = (state_d != S_RD);
      we_n_d      = (state_d != S_WR);
      dq_oe_d     = (state_d == S_WR) || (state_d == S_WR_HOLD);
      sram_addr_d = accept ? addr : sram_addr_q;
      data2fpga_d = ((state_q == S_RD) && (cnt_q == 4'd0)) ? dq_in : data2fpga_q;
   end

   sram_dq_iob #(
      .DATA_W (DATA_W)
   ) u_iob (
      .clk   (clk),
      .rst   (rst),
      .oe_d  (dq_oe_d),
      .load  (accept),
      .din   (data2ram),
      .dq    (sram_dq),
      .dq_in (dq_in)
   );

   assign ready     = ready_q;
   assign data2fpga = data2fpga_q;
   assign sram_addr = sram_addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural async SRAM model;
// follows SRAM_CTRL_TURNAROUND_EN when it is defined for the build.
module tb_sram_ctrl;

   localparam int RD_WAIT = 2;
   localparam int WR_WAIT = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem = 1'b0;
   logic        rw = 1'b0;
   logic [19:0] addr = '0;
   logic [7:0]  data2ram = '0;
   wire         ready;
   wire  [7:0]  data2fpga;
   wire  [19:0] sram_addr;
   wire  [7:0]  sram_dq;
   wire         sram_ce_n, sram_oe_n, sram_we_n;

   always #10 clk = ~clk;

   sram_ctrl #(
      .ADDR_W(20), .DATA_W(8), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
   ) dut (
      .clk(clk), .rst(rst), .mem(mem), .rw(rw), .ready(ready), .addr(addr),
      .data2ram(data2ram), .data2fpga(data2fpga), .sram_addr(sram_addr),
      .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n)
   );

   // Behavioural SRAM: drives on CE#&OE# with WE# high, stores while CE#&WE# are low.
   bit   [7:0] ram [0:1048575];
   logic [7:0] model_rd;
   assign model_rd = ram[sram_addr];
   assign sram_dq  = (!sram_ce_n && !sram_oe_n && sram_we_n) ? model_rd : 8'bz;
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) ram[sram_addr] <= sram_dq;
   end

   wire dq_drv = dut.u_iob.oe_q;

   int n_access = 0;
   logic prev_ce_n = 1'b1;
   always @(negedge clk) begin
      if (!sram_ce_n && prev_ce_n) n_access = n_access + 1;
      prev_ce_n = sram_ce_n;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          op_rw;
      logic [19:0] op_addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t        vecs [8];
   logic [19:0] b2b_addr [4];
   bit          prev_vld = 1'b0;
   bit          prev_rw = 1'b0;

   // One request; counts ready-low, WE#-low, OE#-low and all-strobes-high cycles.
   task automatic do_op(input bit op_rw, input logic [19:0] a, input logic [7:0] d,
                        output int lat, output int we_cyc, output int oe_cyc,
                        output int idle_cyc);
      lat = 0; we_cyc = 0; oe_cyc = 0; idle_cyc = 0;
      @(negedge clk);
      mem = 1'b1; rw = op_rw; addr = a; data2ram = d;
      @(posedge clk);
      #1 mem = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         check("oe_we_overlap", {31'b0, !sram_oe_n && !sram_we_n}, 32'd0);
         check("dq_drive_while_oe", {31'b0, !sram_oe_n && dq_drv}, 32'd0);
         if (ready) break;
         lat++;
         if (!sram_we_n) we_cyc++;
         if (!sram_oe_n) oe_cyc++;
         if (sram_ce_n && sram_oe_n && sram_we_n) idle_cyc++;
      end
   endtask

   initial begin
      int lat, we_c, oe_c, idle_c, exp_lat, cyc, acc, seen, a0;
      bit turn, prev_rdy, in_rd;

      vecs[0] = '{1'b0, 20'h12345, 8'hA5, 8'h00};
      vecs[1] = '{1'b1, 20'h12345, 8'h00, 8'hA5};
      vecs[2] = '{1'b0, 20'h00000, 8'h3C, 8'h00};
      vecs[3] = '{1'b0, 20'hFFFFF, 8'hC3, 8'h00};
      vecs[4] = '{1'b1, 20'hFFFFF, 8'h00, 8'hC3};
      vecs[5] = '{1'b1, 20'h00000, 8'h00, 8'h3C};
      vecs[6] = '{1'b0, 20'h80000, 8'h5A, 8'h00};
      vecs[7] = '{1'b1, 20'h80000, 8'h00, 8'h5A};
      b2b_addr[0] = 20'h00000; b2b_addr[1] = 20'hFFFFF;
      b2b_addr[2] = 20'h00001; b2b_addr[3] = 20'h80000;

      // Reset held for three edges.
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
      check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
      check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      check("rst_dq_released", {31'b0, dq_drv}, 32'd0);
      check("rst_data2fpga", {24'b0, data2fpga}, 32'd0);
      check("rst_sram_addr", {12'b0, sram_addr}, 32'd0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         turn = TURN_EN && prev_vld && (prev_rw != vecs[i].op_rw);
         do_op(vecs[i].op_rw, vecs[i].op_addr, vecs[i].wdata, lat, we_c, oe_c, idle_c);
         exp_lat = (vecs[i].op_rw ? RD_WAIT + 1 : WR_WAIT + 2) + int'(turn);
         check($sformatf("v%0d_latency", i), lat, exp_lat);
         check($sformatf("v%0d_we_cycles", i), we_c, vecs[i].op_rw ? 0 : WR_WAIT);
         check($sformatf("v%0d_oe_cycles", i), oe_c, vecs[i].op_rw ? RD_WAIT : 0);
         check($sformatf("v%0d_idle_cycles", i), idle_c, 1 + int'(turn));
         if (vecs[i].op_rw)
            check($sformatf("v%0d_rdata", i), {24'b0, data2fpga}, {24'b0, vecs[i].exp_rd});
         else
            check($sformatf("v%0d_ram", i), {24'b0, ram[vecs[i].op_addr]}, {24'b0, vecs[i].wdata});
         prev_vld = 1'b1;
         prev_rw  = vecs[i].op_rw;
      end

      // Back-to-back reads with mem held high.
      cyc = 0; acc = 0; seen = 0; prev_rdy = 1'b0; in_rd = 1'b0;
      @(negedge clk);
      mem = 1'b1; rw = 1'b1; addr = b2b_addr[0];
      while (cyc < 80 && !(acc == 4 && ready)) begin
         check("b2b_ready_twice", {31'b0, ready && prev_rdy && mem}, 32'd0);
         prev_rdy = ready;
         if (ready) begin
            @(posedge clk);
            #1 acc++;
            if (acc < 4) addr = b2b_addr[acc];
            else mem = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (!sram_oe_n && !in_rd) begin
            if (seen < 4) check($sformatf("b2b_addr%0d", seen), {12'b0, sram_addr}, {12'b0, b2b_addr[seen]});
            seen++;
         end
         in_rd = !sram_oe_n;
      end
      check("b2b_no_timeout", {31'b0, cyc < 80}, 32'd1);
      check("b2b_accepts", acc, 4);
      check("b2b_reads", seen, 4);
      check("b2b_last_rdata", {24'b0, data2fpga}, 32'h5A);
      prev_rw = 1'b1;

      // mem pulsed while busy must not start a second access.
      a0 = n_access;
      @(negedge clk);
      mem = 1'b1; rw = 1'b0; addr = 20'h00100; data2ram = 8'h77;
      @(posedge clk);
      #1 mem = 1'b0;
      @(negedge clk);
      mem = 1'b1; addr = 20'h00200; data2ram = 8'h88;
      @(negedge clk);
      mem = 1'b0;
      cyc = 0;
      while (!ready && cyc < 40) begin @(negedge clk); cyc++; end
      repeat (3) @(negedge clk);
      check("pulse_no_timeout", {31'b0, cyc < 40}, 32'd1);
      check("pulse_access_count", n_access - a0, 1);
      check("pulse_ram_100", {24'b0, ram[20'h00100]}, 32'h77);
      check("pulse_ram_200", {24'b0, ram[20'h00200]}, 32'h00);
      prev_rw = 1'b0;

      // Reset during the second WR cycle.
      @(negedge clk);
      mem = 1'b1; rw = 1'b0; addr = 20'h00300; data2ram = 8'h99;
      @(posedge clk);
      #1 mem = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (sram_we_n && cyc < 40);
      @(negedge clk);
      check("abort_in_wr2", {31'b0, sram_we_n}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_we_n", {31'b0, sram_we_n}, 32'd1);
      check("abort_ce_n", {31'b0, sram_ce_n}, 32'd1);
      check("abort_dq_released", {31'b0, dq_drv}, 32'd0);
      check("abort_ready", {31'b0, ready}, 32'd1);
      rst = 1'b1;
      prev_vld = 1'b0;

      // Controller recovers from the abort; earlier data still readable.
      do_op(1'b1, 20'h12345, 8'h00, lat, we_c, oe_c, idle_c);
      check("post_abort_latency", lat, RD_WAIT + 1);
      check("post_abort_rdata", {24'b0, data2fpga}, 32'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
